// File: rtl/data_memory_arbiter_if.sv
`default_nettype none
// =============================================================================
// Interface : data_memory_arbiter_if
// Requester, memory and status signals of the data memory arbiter.
// Revision  : 1.0
// =============================================================================
interface data_memory_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              r0_req;
    logic              r0_we;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wdata;
    logic              r0_gnt;
    logic              r0_rvalid;
    logic [DATA_W-1:0] r0_rdata;

    logic              r1_req;
    logic              r1_we;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wdata;
    logic              r1_gnt;
    logic              r1_rvalid;
    logic [DATA_W-1:0] r1_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;
    logic              owner;

    // Requesters plus the memory: everything outside the arbiter.
    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata,
        output r1_req, r1_we, r1_addr, r1_wdata,
        output mem_rdata,
        input  r0_gnt, r0_rvalid, r0_rdata,
        input  r1_gnt, r1_rvalid, r1_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy, owner
    );

    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata,
        input  r1_req, r1_we, r1_addr, r1_wdata,
        input  mem_rdata,
        output r0_gnt, r0_rvalid, r0_rdata,
        output r1_gnt, r1_rvalid, r1_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy, owner
    );
endinterface
`default_nettype wire

// File: rtl/data_memory_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : data_memory_arbiter
// Shares one data memory between the core (r0) and the loader/debug port (r1).
// Define ARB_ROUND_ROBIN_EN for alternating tie-break; default is r0 priority.
// Revision : 1.0
// =============================================================================
module data_memory_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    data_memory_arbiter_if.slave bus
);
    localparam int               CNT_W    = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic              last_owner_q, last_owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              r0_rvalid_q, r0_rvalid_d;
    logic              r1_rvalid_q, r1_rvalid_d;
    logic [DATA_W-1:0] r0_rdata_q, r0_rdata_d;
    logic [DATA_W-1:0] r1_rdata_q, r1_rdata_d;
    logic              win;

    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        if (bus.r0_req && bus.r1_req) begin
            win = ~last_owner_q;
        end else begin
            win = bus.r1_req;
        end
`else
        win = ~bus.r0_req;
`endif
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        r0_rvalid_d  = 1'b0;
        r1_rvalid_d  = 1'b0;
        r0_rdata_d   = r0_rdata_q;
        r1_rdata_d   = r1_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.r0_req || bus.r1_req) begin
                    owner_d      = win;
                    last_owner_d = win;
                    we_d         = win ? bus.r1_we    : bus.r0_we;
                    addr_d       = win ? bus.r1_addr  : bus.r0_addr;
                    wdata_d      = win ? bus.r1_wdata : bus.r0_wdata;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (we_q) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = CNT_ONE;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Counter reaches the latency in the cycle mem_rdata is valid.
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    if (owner_q) begin
                        r1_rdata_d  = bus.mem_rdata;
                        r1_rvalid_d = 1'b1;
                    end else begin
                        r0_rdata_d  = bus.mem_rdata;
                        r0_rvalid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            r0_rvalid_q  <= 1'b0;
            r1_rvalid_q  <= 1'b0;
            r0_rdata_q   <= '0;
            r1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            r0_rvalid_q  <= r0_rvalid_d;
            r1_rvalid_q  <= r1_rvalid_d;
            r0_rdata_q   <= r0_rdata_d;
            r1_rdata_q   <= r1_rdata_d;
        end
    end

    assign bus.mem_en    = (state_q == ST_ISSUE);
    assign bus.mem_we    = (state_q == ST_ISSUE) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.r0_gnt    = (state_q == ST_ISSUE) && !owner_q;
    assign bus.r1_gnt    = (state_q == ST_ISSUE) && owner_q;
    assign bus.r0_rvalid = r0_rvalid_q;
    assign bus.r1_rvalid = r1_rvalid_q;
    assign bus.r0_rdata  = r0_rdata_q;
    assign bus.r1_rdata  = r1_rdata_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.owner     = owner_q;
endmodule
`default_nettype wire
